// File: rtl/fd_window_loader_if.sv
// Handshake and memory/register-file bus of the FAST window loader.
// master = loader side, slave = scanner / memory / detector side.
interface fd_window_loader_if #(
    parameter int ADDR_W = 15
);
    logic              start_valid;
    logic              start_ready;
    logic [7:0]        cx;
    logic [7:0]        cy;
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_data;
    logic [4:0]        RegAddr;
    logic [7:0]        ReadData;
    logic              readEn;
    logic              det_done;
    logic              det_corner;
    logic              res_valid;
    logic              res_ready;
    logic              res_corner;
    logic              res_border;
    logic              res_timeout;
    logic [7:0]        res_x;
    logic [7:0]        res_y;

    modport master (
        input  start_valid, cx, cy, mem_data,
        input  det_done, det_corner, res_ready,
        output start_ready, mem_rd, mem_addr,
        output RegAddr, ReadData, readEn,
        output res_valid, res_corner, res_border,
        output res_timeout, res_x, res_y
    );

    modport slave (
        output start_valid, cx, cy, mem_data,
        output det_done, det_corner, res_ready,
        input  start_ready, mem_rd, mem_addr,
        input  RegAddr, ReadData, readEn,
        input  res_valid, res_corner, res_border,
        input  res_timeout, res_x, res_y
    );
endinterface

// File: rtl/fd_window_loader.sv
// FAST window loader: fetches centre + 16 circle pixels into the
// register file, raises readEn and returns the tagged detector verdict.
module fd_window_loader #(
    parameter int IMG_W   = 160,
    parameter int IMG_H   = 120,
    parameter int ADDR_W  = 15,
    parameter int TIMEOUT = 63
) (
    input logic                clk,
    input logic                nRESET,
    fd_window_loader_if.master bus
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DRAIN,
        EVAL,
        RESULT
    } state_t;

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [7:0] XMAX = 8'(IMG_W - 4);
    localparam logic [7:0] YMAX = 8'(IMG_H - 4);
    localparam logic [4:0] PARK = 5'd17;

    state_t            state;
    logic [7:0]        x_q;
    logic [7:0]        y_q;
    logic [4:0]        slot;
    logic              tag_v;
    logic [4:0]        tag_q;
    logic [CW-1:0]     wcnt;
    logic              mem_rd_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [4:0]        reg_addr_q;
    logic [7:0]        read_data_q;
    logic              read_en_q;
    logic              res_valid_q;
    logic              res_corner_q;
    logic              res_border_q;
    logic              res_timeout_q;

    // Packed {dx,dy} as two 4-bit two's-complement offsets.
    function automatic logic [7:0] offs(input logic [4:0] s);
        case (s)
            5'd1:    offs = 8'h0D;
            5'd2:    offs = 8'h1D;
            5'd3:    offs = 8'h2E;
            5'd4:    offs = 8'h3F;
            5'd5:    offs = 8'h30;
            5'd6:    offs = 8'h31;
            5'd7:    offs = 8'h22;
            5'd8:    offs = 8'h13;
            5'd9:    offs = 8'h03;
            5'd10:   offs = 8'hF3;
            5'd11:   offs = 8'hE2;
            5'd12:   offs = 8'hD1;
            5'd13:   offs = 8'hD0;
            5'd14:   offs = 8'hDF;
            5'd15:   offs = 8'hEE;
            5'd16:   offs = 8'hFD;
            default: offs = 8'h00;
        endcase
    endfunction

    logic [4:0]        nxt_slot;
    logic [7:0]        off;
    logic [7:0]        px;
    logic [7:0]        py;
    logic [ADDR_W-1:0] nxt_addr;
    logic [ADDR_W-1:0] first_addr;
    logic              border;

    assign nxt_slot   = slot + 5'd1;
    assign off        = offs(nxt_slot);
    assign px         = x_q + {{4{off[7]}}, off[7:4]};
    assign py         = y_q + {{4{off[3]}}, off[3:0]};
    assign nxt_addr   = ADDR_W'(py) * ADDR_W'(IMG_W) + ADDR_W'(px);
    assign first_addr = ADDR_W'(bus.cy) * ADDR_W'(IMG_W) + ADDR_W'(bus.cx);
    assign border     = (bus.cx < 8'd3) | (bus.cy < 8'd3) |
                        (bus.cx > XMAX) | (bus.cy > YMAX);

    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            state         <= IDLE;
            x_q           <= '0;
            y_q           <= '0;
            slot          <= '0;
            tag_v         <= 1'b0;
            tag_q         <= '0;
            wcnt          <= '0;
            mem_rd_q      <= 1'b0;
            mem_addr_q    <= '0;
            reg_addr_q    <= PARK;
            read_data_q   <= '0;
            read_en_q     <= 1'b0;
            res_valid_q   <= 1'b0;
            res_corner_q  <= 1'b0;
            res_border_q  <= 1'b0;
            res_timeout_q <= 1'b0;
        end else begin
            // Slot tag follows its read by one cycle, data by two.
            tag_v       <= mem_rd_q;
            tag_q       <= slot;
            reg_addr_q  <= tag_v ? tag_q : PARK;
            read_data_q <= tag_v ? bus.mem_data : 8'd0;
            unique case (state)
                IDLE: begin
                    if (bus.start_valid) begin
                        x_q           <= bus.cx;
                        y_q           <= bus.cy;
                        res_corner_q  <= 1'b0;
                        res_timeout_q <= 1'b0;
                        res_border_q  <= border;
                        if (border) begin
                            state       <= RESULT;
                            res_valid_q <= 1'b1;
                        end else begin
                            state      <= FETCH;
                            slot       <= '0;
                            mem_rd_q   <= 1'b1;
                            mem_addr_q <= first_addr;
                        end
                    end
                end
                FETCH: begin
                    if (slot == 5'd16) begin
                        state    <= DRAIN;
                        mem_rd_q <= 1'b0;
                    end else begin
                        slot       <= nxt_slot;
                        mem_addr_q <= nxt_addr;
                    end
                end
                DRAIN: begin
                    state     <= EVAL;
                    read_en_q <= 1'b1;
                    wcnt      <= '0;
                end
                EVAL: begin
                    if (bus.det_done) begin
                        state        <= RESULT;
                        read_en_q    <= 1'b0;
                        res_valid_q  <= 1'b1;
                        res_corner_q <= bus.det_corner;
                    end else if (wcnt == CW'(TIMEOUT)) begin
                        state         <= RESULT;
                        read_en_q     <= 1'b0;
                        res_valid_q   <= 1'b1;
                        res_timeout_q <= 1'b1;
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
                RESULT: begin
                    if (bus.res_ready) begin
                        state       <= IDLE;
                        res_valid_q <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.start_ready = (state == IDLE);
    assign bus.mem_rd      = mem_rd_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.RegAddr     = reg_addr_q;
    assign bus.ReadData    = read_data_q;
    assign bus.readEn      = read_en_q;
    assign bus.res_valid   = res_valid_q;
    assign bus.res_corner  = res_corner_q;
    assign bus.res_border  = res_border_q;
    assign bus.res_timeout = res_timeout_q;
    assign bus.res_x       = x_q;
    assign bus.res_y       = y_q;

endmodule

// File: tb/tb_fd_window_loader.sv
// Directed bench for fd_window_loader: vector table plus reset and
// back-to-back sequences against a line-memory and register-file model.
module tb_fd_window_loader;

    localparam int W  = 160;
    localparam int H  = 120;
    localparam int AW = 15;

    logic clk    = 1'b0;
    logic nRESET = 1'b0;
    always #5 clk = ~clk;

    fd_window_loader_if #(.ADDR_W(AW)) bus ();

    fd_window_loader #(
        .IMG_W(W), .IMG_H(H), .ADDR_W(AW), .TIMEOUT(63)
    ) dut (
        .clk(clk), .nRESET(nRESET), .bus(bus)
    );

    function automatic logic [7:0] pix(input int a);
        return 8'((a * 13 + (a >> 7) + 5) & 255);
    endfunction

    always @(posedge clk)
        if (bus.mem_rd) bus.mem_data <= pix(int'(bus.mem_addr));

    logic [7:0] rf [0:16];
    always @(posedge clk)
        if (bus.RegAddr < 5'd17) rf[bus.RegAddr] <= bus.ReadData;

    int dxs [0:16] = '{0, 0, 1, 2, 3, 3, 3, 2, 1, 0, -1, -2, -3, -3, -3, -2, -1};
    int dys [0:16] = '{0, -3, -3, -2, -1, 0, 1, 2, 3, 3, 3, 2, 1, 0, -1, -2, -3};

    int npass = 0;
    int ntot  = 0;

    task automatic chk(input string nm, input int act, input int exp);
        ntot++;
        if (act == exp) npass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    int tr_ra   [0:255];
    int tr_addr [0:255];
    int r_tv, r_nrd, r_nre, r_holdbad, r_idle;
    int r_border, r_corner, r_timeout, r_x, r_y;

    task automatic run(input int x, input int y, input int dly,
                       input bit corner, input bit noise, input int hold);
        bit cons;
        cons = 1'b0;
        for (int i = 0; i < 256; i++) begin
            tr_ra[i]   = 17;
            tr_addr[i] = 0;
        end
        for (int i = 0; i < 17; i++) rf[i] = 8'd0;
        r_tv = -1; r_nrd = 0; r_nre = 0; r_holdbad = 0; r_idle = 0;
        r_border = -1; r_corner = -1; r_timeout = -1; r_x = -1; r_y = -1;
        @(negedge clk);
        bus.start_valid = 1'b1;
        bus.cx = 8'(x);
        bus.cy = 8'(y);
        bus.res_ready = 1'b0;
        bus.det_done = 1'b0;
        for (int k = 1; k < 256; k++) begin
            @(negedge clk);
            bus.start_valid = 1'b0;
            if (cons) begin
                r_idle = int'(bus.res_valid == 1'b0 && bus.start_ready == 1'b1);
                break;
            end
            tr_ra[k]   = int'(bus.RegAddr);
            tr_addr[k] = int'(bus.mem_addr);
            if (bus.mem_rd) r_nrd++;
            if (bus.readEn) r_nre++;
            bus.det_done = noise && !bus.readEn && !bus.res_valid;
            if (bus.readEn && dly >= 0 && r_nre - 1 == dly) bus.det_done = 1'b1;
            bus.det_corner = corner;
            if (bus.res_valid) begin
                if (r_tv < 0) begin
                    r_tv      = k;
                    r_border  = int'(bus.res_border);
                    r_corner  = int'(bus.res_corner);
                    r_timeout = int'(bus.res_timeout);
                    r_x       = int'(bus.res_x);
                    r_y       = int'(bus.res_y);
                end
                if (k - r_tv < hold) begin
                    bus.res_ready = 1'b0;
                    if (bus.start_ready || bus.readEn) r_holdbad++;
                    if (int'(bus.res_x) != r_x || int'(bus.res_y) != r_y ||
                        int'(bus.res_corner) != r_corner) r_holdbad++;
                end else begin
                    bus.res_ready = 1'b1;
                    cons = 1'b1;
                end
            end
        end
        bus.res_ready = 1'b0;
        bus.det_done  = 1'b0;
    endtask

    typedef struct {
        int x, y, dly;
        bit corner, noise;
        int hold;
        int tv, nrd, nre;
        bit border, ecorner, timeout;
    } vec_t;

    vec_t v [0:7];

    initial begin
        int bad;
        int a;
        int r1, r2, prev, fv, sr21, e;

        v[0] = '{10, 10, 0, 1, 0, 0, 20, 17, 1, 0, 1, 0};
        v[1] = '{10, 10, 4, 1, 1, 10, 24, 17, 5, 0, 1, 0};
        v[2] = '{2, 50, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0};
        v[3] = '{157, 50, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0};
        v[4] = '{156, 116, 2, 0, 0, 0, 22, 17, 3, 0, 0, 0};
        v[5] = '{3, 3, 0, 1, 0, 2, 20, 17, 1, 0, 1, 0};
        v[6] = '{50, 60, -1, 1, 0, 0, 83, 17, 64, 0, 0, 1};
        v[7] = '{20, 117, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0};

        bus.start_valid = 1'b0;
        bus.cx = '0;
        bus.cy = '0;
        bus.det_done = 1'b0;
        bus.det_corner = 1'b0;
        bus.res_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst RegAddr", int'(bus.RegAddr), 17);
        chk("rst mem_rd", int'(bus.mem_rd), 0);
        chk("rst readEn", int'(bus.readEn), 0);
        chk("rst res_valid", int'(bus.res_valid), 0);
        chk("rst start_ready", int'(bus.start_ready), 1);
        nRESET = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run(v[i].x, v[i].y, v[i].dly, v[i].corner, v[i].noise, v[i].hold);
            chk($sformatf("v%0d res_valid time", i), r_tv, v[i].tv);
            chk($sformatf("v%0d mem_rd count", i), r_nrd, v[i].nrd);
            chk($sformatf("v%0d readEn count", i), r_nre, v[i].nre);
            chk($sformatf("v%0d border", i), r_border, int'(v[i].border));
            chk($sformatf("v%0d corner", i), r_corner, int'(v[i].ecorner));
            chk($sformatf("v%0d timeout", i), r_timeout, int'(v[i].timeout));
            chk($sformatf("v%0d res_x", i), r_x, v[i].x);
            chk($sformatf("v%0d res_y", i), r_y, v[i].y);
            chk($sformatf("v%0d idle after", i), r_idle, 1);
            chk($sformatf("v%0d hold", i), r_holdbad, 0);
            bad = 0;
            for (int k = 1; k < 256; k++) begin
                e = (!v[i].border && k >= 3 && k <= 19) ? k - 3 : 17;
                if (tr_ra[k] != e) bad++;
            end
            chk($sformatf("v%0d RegAddr seq", i), bad, 0);
            if (!v[i].border) begin
                bad = 0;
                for (int s = 0; s < 17; s++) begin
                    a = (v[i].y + dys[s]) * W + v[i].x + dxs[s];
                    if (tr_addr[s + 1] != a) bad++;
                    if (rf[s] != pix(a)) bad++;
                end
                chk($sformatf("v%0d addr/pixels", i), bad, 0);
            end
            if (i == 0) begin
                chk("c10 slot0 addr", tr_addr[1], 1610);
                chk("c10 slot1 addr", tr_addr[2], 1130);
                chk("c10 slot5 addr", tr_addr[6], 1613);
            end
        end

        // Reset in the middle of FETCH
        @(negedge clk);
        bus.start_valid = 1'b1;
        bus.cx = 8'd10;
        bus.cy = 8'd10;
        repeat (8) begin
            @(negedge clk);
            bus.start_valid = 1'b0;
        end
        chk("pre-reset mem_rd", int'(bus.mem_rd), 1);
        nRESET = 1'b0;
        #1;
        chk("mid rst mem_rd", int'(bus.mem_rd), 0);
        chk("mid rst mem_addr", int'(bus.mem_addr), 0);
        chk("mid rst RegAddr", int'(bus.RegAddr), 17);
        chk("mid rst ReadData", int'(bus.ReadData), 0);
        chk("mid rst readEn", int'(bus.readEn), 0);
        chk("mid rst res", int'({bus.res_valid, bus.res_corner,
                                 bus.res_border, bus.res_timeout}), 0);
        chk("mid rst res_xy", int'({bus.res_x, bus.res_y}), 0);
        chk("mid rst start_ready", int'(bus.start_ready), 1);
        @(negedge clk);
        nRESET = 1'b1;
        run(30, 40, 0, 1, 0, 0);
        chk("post rst tv", r_tv, 20);
        chk("post rst corner", r_corner, 1);
        chk("post rst res_x", r_x, 30);

        // Back-to-back candidates with res_ready held high
        r1 = -1; r2 = -1; prev = 0; fv = -1; sr21 = -1; bad = 0;
        @(negedge clk);
        bus.start_valid = 1'b1;
        bus.cx = 8'd40;
        bus.cy = 8'd40;
        bus.res_ready = 1'b1;
        bus.det_corner = 1'b0;
        for (int k = 1; k <= 50; k++) begin
            @(negedge clk);
            if (k == 1) begin
                bus.cx = 8'd60;
                bus.cy = 8'd30;
            end
            if (bus.mem_rd && prev == 0) begin
                if (r1 < 0) r1 = k;
                else if (r2 < 0) r2 = k;
            end
            prev = int'(bus.mem_rd);
            if (r2 > 0) bus.start_valid = 1'b0;
            e = (k >= 3 && k <= 19) ? k - 3 :
                (k >= 24 && k <= 40) ? k - 24 : 17;
            if (int'(bus.RegAddr) != e) bad++;
            if (bus.res_valid && fv < 0) fv = k;
            if (k == 21) sr21 = int'(bus.start_ready);
            bus.det_done = bus.readEn;
        end
        bus.start_valid = 1'b0;
        bus.res_ready = 1'b0;
        bus.det_done = 1'b0;
        chk("b2b first rd", r1, 1);
        chk("b2b second rd", r2, 22);
        chk("b2b first valid", fv, 20);
        chk("b2b ready at 21", sr21, 1);
        chk("b2b RegAddr seq", bad, 0);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
